// File: rtl/frame_store_pkg.sv
// frame_store_pkg: shared row/pixel types and bank-select encoding for the frame store.
// Rev 1.0
`default_nettype none

package frame_store_pkg;

  localparam int ROWS  = 8;
  localparam int COLS  = 16;
  localparam int ROW_W = 3;

  typedef logic [ROW_W-1:0] row_t;
  typedef logic [COLS-1:0]  pix_row_t;

  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_sel_t;

  function automatic bank_sel_t other_bank(input bank_sel_t b);
    return (b == BANK_A) ? BANK_B : BANK_A;
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_store_if.sv
// frame_store_if: writer/scanner bus of the frame store; master = game logic + scanner side.
// Rev 1.0
`default_nettype none

interface frame_store_if;
  import frame_store_pkg::*;

  logic     wr_en;
  row_t     wr_row;
  pix_row_t wr_data;
  logic     commit;
  logic     busy;
  logic     wr_drop;
  logic     rd_req;
  row_t     rd_row;
  logic [7:0] col1;
  logic [7:0] col2;
  logic     rd_valid;
  logic     frame_swap;

  modport master (
    output wr_en, wr_row, wr_data, commit, rd_req, rd_row,
    input  busy, wr_drop, col1, col2, rd_valid, frame_swap
  );

  modport slave (
    input  wr_en, wr_row, wr_data, commit, rd_req, rd_row,
    output busy, wr_drop, col1, col2, rd_valid, frame_swap
  );

endinterface

`default_nettype wire

// File: rtl/frame_bank.sv
// frame_bank: ROWS x COLS register array, synchronous write, async clear, combinational read.
// Rev 1.0
`default_nettype none

module frame_bank
  import frame_store_pkg::*;
(
  input  wire logic clock,
  input  wire logic restart,
  input  wire logic we,
  input  wire row_t     wr_row,
  input  wire pix_row_t wr_data,
  input  wire row_t     rd_row,
  output pix_row_t      rd_data
);

  pix_row_t mem [ROWS];

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    always_ff @(posedge clock or negedge restart) begin
      if (!restart) begin
        mem[r] <= '0;
      end else if (we && (wr_row == row_t'(r))) begin
        mem[r] <= wr_data;
      end
    end
  end

  assign rd_data = mem[rd_row];

endmodule

`default_nettype wire

// File: rtl/frame_store.sv
// frame_store: double-buffered frame memory; the bank swap happens only on a row-0 scan request.
// Rev 1.0
`default_nettype none

module frame_store
  import frame_store_pkg::*;
(
  input  wire logic    clock,
  input  wire logic    restart,
  frame_store_if.slave bus
);

  bank_sel_t  front;
  bank_sel_t  front_nxt;
  logic       pending;
  logic       swap;
  logic       wr_ok;
  pix_row_t   rd_a;
  pix_row_t   rd_b;
  pix_row_t   rd_sel;
  logic       wr_drop;
  logic       rd_valid;
  logic       frame_swap;
  logic [7:0] col1;
  logic [7:0] col2;

  assign swap      = bus.rd_req && (bus.rd_row == '0) && pending;
  assign front_nxt = swap ? other_bank(front) : front;
  assign wr_ok     = bus.wr_en && !pending;

  frame_bank u_bank_a (
    .clock   (clock),
    .restart (restart),
    .we      (wr_ok && (front == BANK_B)),
    .wr_row  (bus.wr_row),
    .wr_data (bus.wr_data),
    .rd_row  (bus.rd_row),
    .rd_data (rd_a)
  );

  frame_bank u_bank_b (
    .clock   (clock),
    .restart (restart),
    .we      (wr_ok && (front == BANK_A)),
    .wr_row  (bus.wr_row),
    .wr_data (bus.wr_data),
    .rd_row  (bus.rd_row),
    .rd_data (rd_b)
  );

  // Swap-then-read: a row-0 request that swaps already sees the new front.
  assign rd_sel = (front_nxt == BANK_A) ? rd_a : rd_b;

  always_ff @(posedge clock or negedge restart) begin
    if (!restart) begin
      front      <= BANK_A;
      pending    <= 1'b0;
      wr_drop    <= 1'b0;
      rd_valid   <= 1'b0;
      frame_swap <= 1'b0;
      col1       <= 8'h00;
      col2       <= 8'h00;
    end else begin
      front      <= front_nxt;
      wr_drop    <= bus.wr_en && pending;
      rd_valid   <= bus.rd_req;
      frame_swap <= swap;
      if (swap) begin
        pending <= 1'b0;
      end else if (bus.commit) begin
        pending <= 1'b1;
      end
      if (bus.rd_req) begin
        col1 <= rd_sel[15:8];
        col2 <= rd_sel[7:0];
      end
    end
  end

  assign bus.busy       = pending;
  assign bus.wr_drop    = wr_drop;
  assign bus.rd_valid   = rd_valid;
  assign bus.frame_swap = frame_swap;
  assign bus.col1       = col1;
  assign bus.col2       = col2;

endmodule

`default_nettype wire
